sdp_stream_fifo: RTL and testbench

SDP_STREAM_FIFO -- requirements
Module: sdp_stream_fifo

---
 rtl/sdp_stream_fifo.sv | 149 ++++++++++++++
 tb/tb_sdp_stream_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdp_stream_fifo.sv
// Stream FIFO over a simple dual-port RAM with 2-cycle read latency.
// A 4-entry register buffer absorbs in-flight reads so R_Data never stalls the RAM.

module if_sdp_ram_l #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter     OR = "TRUE",
  parameter     IF = ""
) (
  input  logic          A_Ck,
  input  logic          A_CE,
  input  logic          A_WE,
  input  logic [AW-1:0] A_Ad,
  input  logic [DW-1:0] A_WD,
  input  logic          B_Ck,
  input  logic          B_CE,
  input  logic [AW-1:0] B_Ad,
  output logic [DW-1:0] B_RD
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  // Port A write
  always_ff @(posedge A_Ck) begin
    if (A_CE && A_WE) mem[A_Ad] <= A_WD;
  end

  // Port B array read register
  always_ff @(posedge B_Ck) begin
    if (B_CE) rd_q <= mem[B_Ad];
  end

  generate
    if (IF != "") begin : g_init
      // Contents are never preloaded; the FIFO does not depend on them.
    end
    if (OR == "TRUE") begin : g_oreg
      logic [DW-1:0] out_q;
      // Optional output register adds the second latency stage
      always_ff @(posedge B_Ck) begin
        if (B_CE) out_q <= rd_q;
      end
      assign B_RD = out_q;
    end else begin : g_noreg
      assign B_RD = rd_q;
    end
  endgenerate

endmodule

module sdp_stream_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          Ck,
  input  logic          Rst,
  input  logic          W_En,
  input  logic [DW-1:0] W_Data,
  output logic          Full,
  output logic          R_Vld,
  input  logic          R_Rdy,
  output logic [DW-1:0] R_Data,
  output logic [AW:0]   Count,
  output logic          Ovf
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          s1;
  logic          s2;
  logic [DW-1:0] buf_q [4];
  logic [1:0]    bwr;
  logic [1:0]    brd;
  logic [2:0]    buf_cnt;
  logic [1:0]    inflight;
  logic          accept;
  logic          issue;
  logic          pop;
  logic          cap;
  logic [DW-1:0] b_rd;

  if_sdp_ram_l #(
    .AW(AW),
    .DW(DW),
    .OR("TRUE"),
    .IF("")
  ) u_ram (
    .A_Ck(Ck),
    .A_CE(accept),
    .A_WE(accept),
    .A_Ad(wr_ptr),
    .A_WD(W_Data),
    .B_Ck(Ck),
    .B_CE(1'b1),
    .B_Ad(rd_ptr),
    .B_RD(b_rd)
  );

  assign Full     = (ram_cnt == DEPTH);
  assign accept   = W_En && !Full;
  assign inflight = {1'b0, s1} + {1'b0, s2};
  // Credits count only buffer slots already committed; this cycle's pop is ignored.
  assign issue    = (ram_cnt != '0) &&
                    ((buf_cnt + {1'b0, inflight}) < 3'd4);
  assign R_Vld    = (buf_cnt != 3'd0);
  assign R_Data   = buf_q[brd];
  assign pop      = R_Vld && R_Rdy;
  assign cap      = s2;
  assign Count    = ram_cnt
                  + {{(AW-1){1'b0}}, inflight}
                  + {{(AW-2){1'b0}}, buf_cnt};

  // Pointers, occupancy counters, read pipeline and overflow flag
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      bwr     <= '0;
      brd     <= '0;
      buf_cnt <= '0;
      Ovf     <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (issue)  rd_ptr <= rd_ptr + AW'(1);
      if (accept && !issue)      ram_cnt <= ram_cnt + (AW+1)'(1);
      else if (issue && !accept) ram_cnt <= ram_cnt - (AW+1)'(1);
      s1 <= issue;
      s2 <= s1;
      if (cap) bwr <= bwr + 2'd1;
      if (pop) brd <= brd + 2'd1;
      if (cap && !pop)      buf_cnt <= buf_cnt + 3'd1;
      else if (pop && !cap) buf_cnt <= buf_cnt - 3'd1;
      if (W_En && Full) Ovf <= 1'b1;
    end
  end

  // Capture RAM read data into the output buffer as each token retires
  always_ff @(posedge Ck) begin
    if (cap) buf_q[bwr] <= b_rd;
  end

endmodule

// File: tb/tb_sdp_stream_fifo.sv
// Bench for sdp_stream_fifo: directed vectors, corner sequences and
// random traffic against a queue-based occupancy/ordering model.

module tb_sdp_stream_fifo;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          Ck = 1'b0;
  logic          Rst = 1'b1;
  logic          W_En = 1'b0;
  logic [DW-1:0] W_Data = '0;
  logic          R_Rdy = 1'b0;
  logic          Full;
  logic          R_Vld;
  logic [DW-1:0] R_Data;
  logic [AW:0]   Count;
  logic          Ovf;

  sdp_stream_fifo #(.AW(AW), .DW(DW)) dut (
    .Ck(Ck),
    .Rst(Rst),
    .W_En(W_En),
    .W_Data(W_Data),
    .Full(Full),
    .R_Vld(R_Vld),
    .R_Rdy(R_Rdy),
    .R_Data(R_Data),
    .Count(Count),
    .Ovf(Ovf)
  );

  always #5 Ck = ~Ck;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb[$];
  int            ages[$];
  int            m_ram;
  int            m_buf;
  bit            m_ovf;

  typedef struct {
    bit            w;
    logic [DW-1:0] d;
    bit            r;
    bit            vld;
    logic [DW-1:0] data;
    int            cnt;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    ages.delete();
    m_ram = 0;
    m_buf = 0;
    m_ovf = 0;
  endtask

  task automatic do_reset();
    W_En  = 1'b0;
    R_Rdy = 1'b0;
    Rst   = 1'b1;
    #2;
    chk("rst_full", Full, 0);
    chk("rst_vld", R_Vld, 0);
    chk("rst_count", Count, 0);
    chk("rst_ovf", Ovf, 0);
    @(posedge Ck);
    #1;
    Rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    bit acc;
    bit iss;
    bit pop;
    int cap;
    W_En   = w;
    W_Data = d;
    R_Rdy  = r;
    acc = w && (m_ram != DEPTH);
    if (w && m_ram == DEPTH) m_ovf = 1;
    iss = (m_ram > 0) && ((m_buf + ages.size()) < 4);
    pop = (m_buf > 0) && r;
    @(posedge Ck);
    #1;
    cap = 0;
    foreach (ages[k]) ages[k]--;
    while (ages.size() > 0 && ages[0] == 0) begin
      void'(ages.pop_front());
      cap++;
    end
    if (iss) ages.push_back(2);
    m_ram += int'(acc) - int'(iss);
    m_buf += cap - int'(pop);
    if (acc) sb.push_back(d);
    if (pop) void'(sb.pop_front());
    chk("count", Count, m_ram + ages.size() + m_buf);
    chk("occupancy", Count, sb.size());
    chk("vld", R_Vld, m_buf > 0);
    chk("full", Full, m_ram == DEPTH);
    chk("ovf", Ovf, m_ovf);
    if (m_buf > 0) chk("data", R_Data, sb[0]);
  endtask

  initial begin
    int got;

    tv[0] = '{w:1, d:8'hA5, r:0, vld:0, data:8'h00, cnt:1};
    tv[1] = '{w:0, d:8'h00, r:0, vld:0, data:8'h00, cnt:1};
    tv[2] = '{w:0, d:8'h00, r:0, vld:0, data:8'h00, cnt:1};
    tv[3] = '{w:0, d:8'h00, r:0, vld:1, data:8'hA5, cnt:1};
    tv[4] = '{w:0, d:8'h00, r:0, vld:1, data:8'hA5, cnt:1};
    tv[5] = '{w:0, d:8'h00, r:1, vld:0, data:8'h00, cnt:0};
    tv[6] = '{w:0, d:8'h00, r:1, vld:0, data:8'h00, cnt:0};
    tv[7] = '{w:0, d:8'h00, r:0, vld:0, data:8'h00, cnt:0};

    // reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 8'h00, i[0]);

    // single word latency and pop
    for (int i = 0; i < 8; i++) begin
      step(tv[i].w, tv[i].d, tv[i].r);
      chk("tv_vld", R_Vld, tv[i].vld);
      chk("tv_cnt", Count, tv[i].cnt);
      if (tv[i].vld) chk("tv_data", R_Data, tv[i].data);
    end

    // fill to full, overflow, drain in order
    do_reset();
    for (int i = 0; i < 24; i++) step(1, DW'(i), 0);
    chk("fill_full", Full, 1);
    chk("fill_count", Count, 20);
    chk("fill_ovf", Ovf, 1);
    got = 0;
    for (int c = 0; c < 100 && got < 20; c++) begin
      if (R_Vld) begin
        chk("drain_order", R_Data, got);
        got++;
      end
      step(0, 8'h00, 1);
    end
    chk("drain_all", got, 20);
    chk("drain_empty", Count, 0);

    // continuous streaming through pointer wraps
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1, DW'(i), 1);
      if (i >= 3) begin
        chk("stream_vld", R_Vld, 1);
        chk("stream_data", R_Data, DW'(i - 3));
      end
    end
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1);
    chk("stream_empty", Count, 0);

    // reset with words queued and in flight
    do_reset();
    for (int i = 0; i < 12; i++) step(1, DW'(8'h50 + i), 0);
    chk("pre_rst_count", Count, 12);
    do_reset();
    step(1, 8'h3C, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
    chk("post_rst_vld", R_Vld, 1);
    chk("post_rst_data", R_Data, 8'h3C);
    step(0, 8'h00, 1);
    chk("post_rst_empty", Count, 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 10000; i++)
      step(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
